// File: rtl/lmdpl_phase_sequencer.sv
// Phase sequencer for a pipelined LMDPL dual-rail datapath: each round fetches a fresh mask,
// precharges every net, releases the stages in order and then strobes the round register.
module lmdpl_phase_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int PRE_CYCLES  = 2,
    parameter int EVAL_CYCLES = 1,
    parameter int N_ROUNDS    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mask_ack,
    output logic                mask_req,
    output logic                pre_en,
    output logic [N_STAGES-1:0] eval_en,
    output logic                cap_en,
    output logic [3:0]          round_cnt,
    output logic                busy,
    output logic                done
);

    localparam int MAX_CYC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int STG_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD  = CNT_W'(EVAL_CYCLES - 1);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N_STAGES - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(N_ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MASK = 3'd1,
        ST_PRE  = 3'd2,
        ST_EVAL = 3'd3,
        ST_CAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [STG_W-1:0]   stage_r, stage_s;
    logic [3:0]         round_s;

    logic                mask_req_s;
    logic                pre_en_s;
    logic [N_STAGES-1:0] eval_en_s;
    logic                cap_en_s;
    logic                busy_s;
    logic                done_s;

    // Next-state logic: phase transitions, dwell counter and stage/round indices.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        stage_s = stage_r;
        round_s = round_cnt;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_MASK;
                    round_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MASK: begin
                if (mask_ack) begin
                    state_s = ST_PRE;
                    cnt_s   = PRE_LOAD;
                end else begin
                    state_s = ST_MASK;
                end
            end
            ST_PRE: begin
                if (cnt_r == CNT_W'(0)) begin
                    state_s = ST_EVAL;
                    cnt_s   = EVAL_LOAD;
                    stage_s = STG_W'(0);
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_EVAL: begin
                // A stage releases the next only after its full settle time has elapsed.
                if (cnt_r == CNT_W'(0)) begin
                    if (stage_r == LAST_STAGE) begin
                        state_s = ST_CAP;
                    end else begin
                        stage_s = stage_r + STG_W'(1);
                        cnt_s   = EVAL_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_CAP: begin
                if (round_cnt == LAST_ROUND) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MASK;
                    round_s = round_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        mask_req_s = (state_s == ST_MASK);
        pre_en_s   = (state_s == ST_IDLE) || (state_s == ST_MASK) ||
                     (state_s == ST_PRE)  || (state_s == ST_DONE);
        cap_en_s   = (state_s == ST_CAP);
        busy_s     = (state_s != ST_IDLE) && (state_s != ST_DONE);
        done_s     = (state_s == ST_DONE);
        eval_en_s  = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            eval_en_s[i] = (state_s == ST_CAP) ||
                           ((state_s == ST_EVAL) && (int'(stage_s) >= i));
        end
    end

    // State, counters and registered outputs; reset leaves the datapath precharged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            stage_r   <= '0;
            round_cnt <= 4'd0;
            mask_req  <= 1'b0;
            pre_en    <= 1'b1;
            eval_en   <= '0;
            cap_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            stage_r   <= stage_s;
            round_cnt <= round_s;
            mask_req  <= mask_req_s;
            pre_en    <= pre_en_s;
            eval_en   <= eval_en_s;
            cap_en    <= cap_en_s;
            busy      <= busy_s;
            done      <= done_s;
        end
    end

endmodule

// File: tb/tb_lmdpl_phase_sequencer.sv
// Directed bench for lmdpl_phase_sequencer: a default instance and a 2-stage/3-cycle/1-round
// instance, each compared cycle by cycle against a phase-by-phase expected trace.
module tb_lmdpl_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, ack_a, start_b, ack_b;
    logic       mreq_a, pre_a, cap_a, busy_a, done_a;
    logic [3:0] eval_a, round_a;
    logic       mreq_b, pre_b, cap_b, busy_b, done_b;
    logic [1:0] eval_b;
    logic [3:0] round_b;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [16:0] exp;
        bit          ack;
        bit          st;
    } step_t;

    step_t q[$];

    always #5 clk = ~clk;

    lmdpl_phase_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mask_ack(ack_a),
        .mask_req(mreq_a), .pre_en(pre_a), .eval_en(eval_a), .cap_en(cap_a),
        .round_cnt(round_a), .busy(busy_a), .done(done_a)
    );

    lmdpl_phase_sequencer #(
        .N_STAGES(2), .PRE_CYCLES(2), .EVAL_CYCLES(3), .N_ROUNDS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mask_ack(ack_b),
        .mask_req(mreq_b), .pre_en(pre_b), .eval_en(eval_b), .cap_en(cap_b),
        .round_cnt(round_b), .busy(busy_b), .done(done_b)
    );

    // Packed view: {mask_req, pre_en, eval_en[7:0], cap_en, round_cnt[3:0], busy, done}
    function automatic logic [16:0] pk(input bit mr, input bit pr, input logic [7:0] ev,
                                       input bit cp, input logic [3:0] rc, input bit bz,
                                       input bit dn);
        return {mr, pr, ev, cp, rc, bz, dn};
    endfunction

    function automatic logic [16:0] obs(input bit which);
        if (which) return pk(mreq_b, pre_b, {6'd0, eval_b}, cap_b, round_b, busy_b, done_b);
        else       return pk(mreq_a, pre_a, {4'd0, eval_a}, cap_a, round_a, busy_a, done_a);
    endfunction

    function automatic void push(input logic [16:0] e, input bit a, input bit s);
        step_t t;
        t.exp = e;
        t.ack = a;
        t.st  = s;
        q.push_back(t);
    endfunction

    // Expected trace from the phase description; cycle 1 is the first cycle after start acceptance.
    task automatic build(input int ns, input int ec, input int nr,
                         input int stall_round, input int stall_len, input bit noisy);
        logic [7:0] full;
        logic [7:0] th;
        q.delete();
        full = 8'((1 << ns) - 1);
        for (int r = 0; r < nr; r++) begin
            int ml;
            ml = (r == stall_round) ? stall_len + 1 : 1;
            for (int j = 0; j < ml; j++)
                push(pk(1'b1, 1'b1, 8'd0, 1'b0, 4'(r), 1'b1, 1'b0), (j == ml - 1), noisy);
            for (int j = 0; j < 2; j++)
                push(pk(1'b0, 1'b1, 8'd0, 1'b0, 4'(r), 1'b1, 1'b0), noisy ? (j == 0) : 1'b1, noisy);
            for (int s = 0; s < ns; s++) begin
                th = 8'((1 << (s + 1)) - 1);
                for (int j = 0; j < ec; j++)
                    push(pk(1'b0, 1'b0, th, 1'b0, 4'(r), 1'b1, 1'b0),
                         noisy ? bit'((s + j) % 2) : 1'b1, noisy);
            end
            push(pk(1'b0, 1'b0, full, 1'b1, 4'(r), 1'b1, 1'b0), !noisy, noisy);
        end
        push(pk(1'b0, 1'b1, 8'd0, 1'b0, 4'(nr - 1), 1'b0, 1'b1), 1'b0, 1'b0);
        push(pk(1'b0, 1'b1, 8'd0, 1'b0, 4'(nr - 1), 1'b0, 1'b0), 1'b0, 1'b0);
        push(pk(1'b0, 1'b1, 8'd0, 1'b0, 4'(nr - 1), 1'b0, 1'b0), 1'b0, 1'b0);
    endtask

    task automatic drive(input bit which, input bit s, input bit a);
        if (which) begin
            start_b = s;
            ack_b   = a;
        end else begin
            start_a = s;
            ack_a   = a;
        end
    endtask

    // Start the selected instance and compare up to 'limit' cycles of the queued trace.
    task automatic run(input bit which, input string name, input int limit);
        logic [16:0] got;
        logic [7:0]  ev, prev_ev, full;
        full = which ? 8'h03 : 8'h0f;
        prev_ev = 8'd0;
        @(negedge clk);
        drive(which, 1'b1, 1'b0);
        @(posedge clk);
        for (int k = 0; k < q.size() && k < limit; k++) begin
            @(negedge clk);
            got = obs(which);
            ev  = got[14:7];
            total++;
            if (got !== q[k].exp)
                $display("FAIL %s cycle %0d: got %h expected %h", name, k + 1, got, q[k].exp);
            else
                passed++;
            total++;
            if (got[15] && (ev != 8'd0))
                $display("FAIL %s_overlap cycle %0d: pre_en=1 with eval_en=%h, expected eval_en=0",
                         name, k + 1, ev);
            else
                passed++;
            if (got[6]) begin
                total++;
                if (prev_ev !== full)
                    $display("FAIL %s_cap_prev cycle %0d: eval_en before cap %h, expected %h",
                             name, k + 1, prev_ev, full);
                else
                    passed++;
            end
            prev_ev = ev;
            drive(which, q[k].st, q[k].ack);
        end
        drive(which, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [16:0] rv;
        rv = pk(1'b0, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            total++;
            if (obs(1'b0) !== rv) $display("FAIL reset_a: got %h expected %h", obs(1'b0), rv);
            else passed++;
            total++;
            if (obs(1'b1) !== rv) $display("FAIL reset_b: got %h expected %h", obs(1'b1), rv);
            else passed++;
            rst = 1'b0;
        end
    endtask

    task automatic test_basic();
        build(4, 1, 10, -1, 0, 1'b0);
        run(1'b0, "basic", 1000);
    endtask

    task automatic test_mask_stall();
        build(4, 1, 10, 3, 5, 1'b0);
        run(1'b0, "mask_stall", 1000);
    endtask

    task automatic test_params();
        build(2, 3, 1, -1, 0, 1'b0);
        run(1'b1, "params", 1000);
    endtask

    task automatic test_midop_reset();
        logic [16:0] rv;
        rv = pk(1'b0, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        build(4, 1, 10, -1, 0, 1'b0);
        run(1'b0, "pre_reset", 45);
        drive(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs(1'b0) !== rv) $display("FAIL midop_reset: got %h expected %h", obs(1'b0), rv);
        else passed++;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (obs(1'b0) !== rv) $display("FAIL after_reset_idle cycle %0d: got %h expected %h",
                                           k, obs(1'b0), rv);
            else passed++;
        end
        drive(1'b0, 1'b0, 1'b0);
        build(4, 1, 10, -1, 0, 1'b0);
        run(1'b0, "restart", 1000);
    endtask

    task automatic test_back_to_back_noise();
        build(4, 1, 10, -1, 0, 1'b1);
        run(1'b0, "noise", 1000);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        ack_a   = 1'b0;
        start_b = 1'b0;
        ack_b   = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_mask_stall();
        test_params();
        test_midop_reset();
        test_back_to_back_noise();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
